// File: rtl/bitblaster_pkg.sv
// Shared types for the parametrised BitBlaster core.
// Opcode, class and FSM state encodings plus width helpers.
package bitblaster_pkg;

    typedef enum logic [3:0] {
        FN_LD  = 4'h0,
        FN_CP  = 4'h1,
        FN_ADD = 4'h2,
        FN_SUB = 4'h3,
        FN_INV = 4'h4,
        FN_FLP = 4'h5,
        FN_AND = 4'h6,
        FN_OR  = 4'h7,
        FN_XOR = 4'h8,
        FN_LSL = 4'h9,
        FN_LSR = 4'hA,
        FN_ASR = 4'hB
    } fn_e;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_RSV  = 2'b01,
        CLS_ADDI = 2'b10,
        CLS_SUBI = 2'b11
    } cls_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_COPY,
        S_EXEC1,
        S_LOADA,
        S_EXEC,
        S_WRITE,
        S_ILLEGAL
    } state_e;

    function automatic int ra_w(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int imm_w(input int w, input int nregs);
        return w - 2 - ra_w(nregs);
    endfunction

endpackage

// File: rtl/bitblaster_alu_n.sv
// Combinational BitBlaster ALU: result plus zero/negative flags.
// Unary ops (inv, flp) act on the operand input only.
module bitblaster_alu_n
    import bitblaster_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] op,
    input  logic [3:0]   fn,
    output logic [W-1:0] res,
    output logic         z,
    output logic         n
);

    localparam logic [W-1:0] ONE = W'(1);

    // Shift amounts use the whole operand; native shifts already give
    // zero / full sign fill once the amount reaches W.
    always_comb begin
        res = '0;
        unique case (fn)
            FN_ADD:  res = a + op;
            FN_SUB:  res = a + ~op + ONE;
            FN_INV:  res = ~op + ONE;
            FN_FLP:  res = ~op;
            FN_AND:  res = a & op;
            FN_OR:   res = a | op;
            FN_XOR:  res = a ^ op;
            FN_LSL:  res = a << op;
            FN_LSR:  res = a >> op;
            FN_ASR:  res = $unsigned($signed(a) >>> op);
            default: res = '0;
        endcase
    end

    assign z = (res == '0);
    assign n = res[W-1];

endmodule

// File: rtl/bitblaster_core_n.sv
// BitBlaster core: register file, A/G ALU registers and sequencer.
// All state changes on the falling edge of CLKb; CLR is synchronous.
module bitblaster_core_n
    import bitblaster_pkg::*;
#(
    parameter int W     = 10,
    parameter int NREGS = 4
) (
    input  logic                     CLKb,
    input  logic                     CLR,
    input  logic [W-1:0]             INSTR,
    input  logic                     INSTR_VALID,
    output logic                     INSTR_READY,
    input  logic [W-1:0]             DATA,
    input  logic                     DATA_VALID,
    output logic                     DATA_READY,
    input  logic [$clog2(NREGS)-1:0] RDA1,
    output logic [W-1:0]             Q1,
    output logic [W-1:0]             BUS,
    output logic [1:0]               TIME,
    output logic                     DONE,
    output logic                     ERR,
    output logic                     FLAG_Z,
    output logic                     FLAG_N
);

    localparam int RA = ra_w(NREGS);
    localparam int IW = imm_w(W, NREGS);

    state_e         state, state_n, dec;
    logic [W-1:0]   regs [NREGS];
    logic [W-1:0]   ir, a_q, g_q;
    logic [1:0]     time_q, time_n;
    logic           done_n, err_n;
    logic           ir_ld, a_ld, g_ld, we;
    logic [W-1:0]   wdata;
    logic [RA-1:0]  rx, ry;
    logic [1:0]     cls, in_cls;
    logic [3:0]     in_fn, alu_fn;
    logic [W-1:0]   imm, op_b, alu_res;
    logic           alu_z, alu_n;

    assign cls  = ir[W-1:W-2];
    assign rx   = ir[W-3 -: RA];
    assign ry   = ir[W-3-RA -: RA];
    assign imm  = {{(W-IW){1'b0}}, ir[IW-1:0]};
    assign op_b = (cls == CLS_ALU) ? regs[ry] : imm;

    always_comb begin
        alu_fn = ir[3:0];
        if (cls == CLS_ADDI) alu_fn = FN_ADD;
        if (cls == CLS_SUBI) alu_fn = FN_SUB;
    end

    bitblaster_alu_n #(.W(W)) u_alu (
        .a   (a_q),
        .op  (op_b),
        .fn  (alu_fn),
        .res (alu_res),
        .z   (alu_z),
        .n   (alu_n)
    );

    // Decode straight from INSTR so the accept edge picks the first step.
    assign in_cls = INSTR[W-1:W-2];
    assign in_fn  = INSTR[3:0];

    always_comb begin
        dec = S_ILLEGAL;
        unique case (in_cls)
            CLS_ADDI, CLS_SUBI: dec = S_LOADA;
            CLS_ALU: begin
                unique case (in_fn)
                    FN_LD:           dec = S_LOAD_WAIT;
                    FN_CP:           dec = S_COPY;
                    FN_INV, FN_FLP:  dec = S_EXEC1;
                    FN_ADD, FN_SUB,
                    FN_AND, FN_OR,
                    FN_XOR, FN_LSL,
                    FN_LSR, FN_ASR:  dec = S_LOADA;
                    default:         dec = S_ILLEGAL;
                endcase
            end
            default: dec = S_ILLEGAL;
        endcase
    end

    always_comb begin
        state_n = state;
        time_n  = time_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        ir_ld   = 1'b0;
        a_ld    = 1'b0;
        g_ld    = 1'b0;
        we      = 1'b0;
        wdata   = g_q;
        BUS     = '0;
        unique case (state)
            S_IDLE: begin
                if (INSTR_VALID) begin
                    ir_ld   = 1'b1;
                    time_n  = 2'd1;
                    state_n = dec;
                end
            end
            S_LOAD_WAIT: begin
                BUS = DATA;
                if (DATA_VALID) begin
                    we      = 1'b1;
                    wdata   = DATA;
                    done_n  = 1'b1;
                    time_n  = 2'd0;
                    state_n = S_IDLE;
                end
            end
            S_COPY: begin
                BUS     = regs[ry];
                we      = 1'b1;
                wdata   = regs[ry];
                done_n  = 1'b1;
                time_n  = 2'd0;
                state_n = S_IDLE;
            end
            S_EXEC1: begin
                BUS     = regs[ry];
                g_ld    = 1'b1;
                time_n  = time_q + 2'd1;
                state_n = S_WRITE;
            end
            S_LOADA: begin
                BUS     = regs[rx];
                a_ld    = 1'b1;
                time_n  = time_q + 2'd1;
                state_n = S_EXEC;
            end
            S_EXEC: begin
                BUS     = op_b;
                g_ld    = 1'b1;
                time_n  = time_q + 2'd1;
                state_n = S_WRITE;
            end
            S_WRITE: begin
                BUS     = g_q;
                we      = 1'b1;
                done_n  = 1'b1;
                time_n  = 2'd0;
                state_n = S_IDLE;
            end
            S_ILLEGAL: begin
                done_n  = 1'b1;
                err_n   = 1'b1;
                time_n  = 2'd0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(negedge CLKb) begin
        if (CLR) begin
            state  <= S_IDLE;
            time_q <= 2'd0;
            DONE   <= 1'b0;
            ERR    <= 1'b0;
            ir     <= '0;
            a_q    <= '0;
            g_q    <= '0;
            FLAG_Z <= 1'b0;
            FLAG_N <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state  <= state_n;
            time_q <= time_n;
            DONE   <= done_n;
            ERR    <= err_n;
            if (ir_ld) ir <= INSTR;
            if (a_ld) a_q <= regs[rx];
            if (g_ld) begin
                g_q    <= alu_res;
                FLAG_Z <= alu_z;
                FLAG_N <= alu_n;
            end
            if (we) regs[rx] <= wdata;
        end
    end

    assign INSTR_READY = (state == S_IDLE);
    assign DATA_READY  = (state == S_LOAD_WAIT);
    assign TIME        = time_q;
    assign Q1          = regs[RDA1];

endmodule

// File: tb/tb_bitblaster_core_n.sv
// Directed bench for bitblaster_core_n (W=10, NREGS=4).
// Inputs change and outputs are sampled on the rising edge of CLKb.
module tb_bitblaster_core_n;

    logic       CLKb = 1'b1;
    logic       CLR = 1'b1;
    logic [9:0] INSTR = '0;
    logic       INSTR_VALID = 1'b0;
    logic       INSTR_READY;
    logic [9:0] DATA = '0;
    logic       DATA_VALID = 1'b0;
    logic       DATA_READY;
    logic [1:0] RDA1 = '0;
    logic [9:0] Q1, BUS;
    logic [1:0] TIME;
    logic       DONE, ERR, FLAG_Z, FLAG_N;

    int checks = 0;
    int failures = 0;

    always #5 CLKb = ~CLKb;

    bitblaster_core_n #(.W(10), .NREGS(4)) dut (
        .CLKb        (CLKb),
        .CLR         (CLR),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .DATA        (DATA),
        .DATA_VALID  (DATA_VALID),
        .DATA_READY  (DATA_READY),
        .RDA1        (RDA1),
        .Q1          (Q1),
        .BUS         (BUS),
        .TIME        (TIME),
        .DONE        (DONE),
        .ERR         (ERR),
        .FLAG_Z      (FLAG_Z),
        .FLAG_N      (FLAG_N)
    );

    function automatic logic [9:0] r2(input logic [3:0] fn,
                                      input logic [1:0] rx,
                                      input logic [1:0] ry);
        return {2'b00, rx, ry, fn};
    endfunction

    function automatic logic [9:0] ri(input logic [1:0] cls,
                                      input logic [1:0] rx,
                                      input logic [5:0] imm);
        return {cls, rx, imm};
    endfunction

    task automatic peek(input logic [1:0] idx, output logic [9:0] v);
        RDA1 = idx;
        #1;
        v = Q1;
    endtask

    task automatic load_reg(input logic [1:0] idx, input logic [9:0] val);
        @(posedge CLKb);
        INSTR = r2(4'h0, idx, 2'd0);
        INSTR_VALID = 1'b1;
        DATA = val;
        DATA_VALID = 1'b1;
        @(negedge CLKb);
        @(posedge CLKb);
        INSTR_VALID = 1'b0;
        @(negedge CLKb);
        @(posedge CLKb);
        DATA_VALID = 1'b0;
    endtask

    // Issue one instruction and count edges after acceptance until DONE.
    task automatic run(input logic [9:0] ins, output int steps,
                       output logic ok, output logic err);
        @(posedge CLKb);
        INSTR = ins;
        INSTR_VALID = 1'b1;
        @(negedge CLKb);
        @(posedge CLKb);
        INSTR_VALID = 1'b0;
        steps = 0;
        ok = 1'b0;
        err = 1'b0;
        repeat (8) begin
            if (!ok) begin
                @(negedge CLKb);
                @(posedge CLKb);
                #1;
                steps++;
                if (DONE) begin
                    ok = 1'b1;
                    err = ERR;
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [9:0] v;
        CLR = 1'b1;
        repeat (2) @(negedge CLKb);
        @(posedge CLKb);
        CLR = 1'b0;
        #1;
        checks++;
        if (INSTR_READY !== 1'b1 || DATA_READY !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b%b exp=10", INSTR_READY, DATA_READY);
        end
        checks++;
        if ({TIME, DONE, ERR, FLAG_Z, FLAG_N} !== 6'b0 || BUS !== 10'h0) begin
            failures++;
            $display("FAIL reset_status time=%0d d=%b e=%b z=%b n=%b bus=%h",
                     TIME, DONE, ERR, FLAG_Z, FLAG_N, BUS);
        end
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), v);
            checks++;
            if (v !== 10'h0) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h exp=000", i, v);
            end
        end
    endtask

    task automatic test_ld_stall;
        logic [9:0] v;
        @(posedge CLKb);
        INSTR = 10'b00_10_000000;
        INSTR_VALID = 1'b1;
        @(negedge CLKb);
        @(posedge CLKb);
        INSTR_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (DATA_READY !== 1'b1 || TIME !== 2'd1 || DONE !== 1'b0) begin
                failures++;
                $display("FAIL ld_stall%0d rdy=%b time=%0d done=%b exp=1,1,0",
                         i, DATA_READY, TIME, DONE);
            end
            @(negedge CLKb);
            @(posedge CLKb);
        end
        DATA = 10'h155;
        DATA_VALID = 1'b1;
        #1;
        checks++;
        if (BUS !== 10'h155) begin
            failures++;
            $display("FAIL ld_bus got=%h exp=155", BUS);
        end
        @(negedge CLKb);
        @(posedge CLKb);
        DATA_VALID = 1'b0;
        #1;
        checks++;
        if (DONE !== 1'b1 || TIME !== 2'd0 || INSTR_READY !== 1'b1) begin
            failures++;
            $display("FAIL ld_done done=%b time=%0d rdy=%b exp=1,0,1",
                     DONE, TIME, INSTR_READY);
        end
        peek(2'd2, v);
        checks++;
        if (v !== 10'h155) begin
            failures++;
            $display("FAIL ld_r2 got=%h exp=155", v);
        end
        @(negedge CLKb);
        @(posedge CLKb);
        #1;
        checks++;
        if (DONE !== 1'b0) begin
            failures++;
            $display("FAIL ld_done_pulse got=%b exp=0", DONE);
        end
    endtask

    task automatic test_arith;
        logic [9:0] v;
        int st;
        logic ok, er;
        load_reg(2'd0, 10'd5);
        load_reg(2'd1, 10'd3);
        @(posedge CLKb);
        INSTR = r2(4'h2, 2'd0, 2'd1);
        INSTR_VALID = 1'b1;
        @(negedge CLKb);
        @(posedge CLKb);
        INSTR_VALID = 1'b0;
        #1;
        checks++;
        if (TIME !== 2'd1 || BUS !== 10'd5) begin
            failures++;
            $display("FAIL add_loada time=%0d bus=%h exp=1,005", TIME, BUS);
        end
        @(negedge CLKb);
        @(posedge CLKb);
        #1;
        checks++;
        if (TIME !== 2'd2 || BUS !== 10'd3) begin
            failures++;
            $display("FAIL add_exec time=%0d bus=%h exp=2,003", TIME, BUS);
        end
        @(negedge CLKb);
        @(posedge CLKb);
        #1;
        checks++;
        if (TIME !== 2'd3 || BUS !== 10'd8 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL add_write time=%0d bus=%h done=%b exp=3,008,0",
                     TIME, BUS, DONE);
        end
        @(negedge CLKb);
        @(posedge CLKb);
        #1;
        peek(2'd0, v);
        checks++;
        if (DONE !== 1'b1 || TIME !== 2'd0 || v !== 10'd8) begin
            failures++;
            $display("FAIL add_done done=%b time=%0d r0=%h exp=1,0,008",
                     DONE, TIME, v);
        end
        run(r2(4'h3, 2'd1, 2'd0), st, ok, er);
        peek(2'd1, v);
        checks++;
        if (!ok || st != 3 || v !== 10'h3FB || FLAG_N !== 1'b1 || FLAG_Z !== 1'b0) begin
            failures++;
            $display("FAIL sub ok=%b steps=%0d r1=%h n=%b z=%b exp=1,3,3fb,1,0",
                     ok, st, v, FLAG_N, FLAG_Z);
        end
    endtask

    task automatic test_unary;
        logic [9:0] v;
        int st;
        logic ok, er;
        run(r2(4'h4, 2'd3, 2'd1), st, ok, er);
        peek(2'd3, v);
        checks++;
        if (!ok || st != 2 || v !== 10'h005) begin
            failures++;
            $display("FAIL inv ok=%b steps=%0d r3=%h exp=1,2,005", ok, st, v);
        end
        run(r2(4'h5, 2'd3, 2'd3), st, ok, er);
        peek(2'd3, v);
        checks++;
        if (!ok || st != 2 || v !== 10'h3FA) begin
            failures++;
            $display("FAIL flp ok=%b steps=%0d r3=%h exp=1,2,3fa", ok, st, v);
        end
        run(r2(4'h1, 2'd2, 2'd3), st, ok, er);
        peek(2'd2, v);
        checks++;
        if (!ok || st != 1 || v !== 10'h3FA || FLAG_N !== 1'b1) begin
            failures++;
            $display("FAIL cp ok=%b steps=%0d r2=%h n=%b exp=1,1,3fa,1",
                     ok, st, v, FLAG_N);
        end
    endtask

    task automatic test_logic;
        logic [9:0] v;
        logic [9:0] exp_v [3];
        logic [3:0] fns [3];
        int st;
        logic ok, er;
        exp_v = '{10'h0C0, 10'h3FC, 10'h33C};
        fns = '{4'h6, 4'h7, 4'h8};
        load_reg(2'd1, 10'h3CC);
        for (int i = 0; i < 3; i++) begin
            load_reg(2'd0, 10'h0F0);
            run(r2(fns[i], 2'd0, 2'd1), st, ok, er);
            peek(2'd0, v);
            checks++;
            if (!ok || v !== exp_v[i]) begin
                failures++;
                $display("FAIL logic_fn%h ok=%b r0=%h exp=%h", fns[i], ok, v, exp_v[i]);
            end
        end
        run(r2(4'h3, 2'd1, 2'd1), st, ok, er);
        peek(2'd1, v);
        checks++;
        if (!ok || v !== 10'h0 || FLAG_Z !== 1'b1) begin
            failures++;
            $display("FAIL sub_self ok=%b r1=%h z=%b exp=1,000,1", ok, v, FLAG_Z);
        end
    endtask

    task automatic test_shift;
        logic [9:0] v;
        logic [9:0] exp_v [4];
        logic [3:0] fns [4];
        logic [1:0] rys [4];
        logic       zs [4];
        int st;
        logic ok, er;
        exp_v = '{10'h3FF, 10'h000, 10'h300, 10'h000};
        fns = '{4'hB, 4'hA, 4'hB, 4'h9};
        rys = '{2'd1, 2'd1, 2'd2, 2'd2};
        zs = '{1'b0, 1'b1, 1'b0, 1'b1};
        load_reg(2'd1, 10'd12);
        load_reg(2'd2, 10'd1);
        for (int i = 0; i < 4; i++) begin
            load_reg(2'd0, 10'h200);
            run(r2(fns[i], 2'd0, rys[i]), st, ok, er);
            peek(2'd0, v);
            checks++;
            if (!ok || v !== exp_v[i] || FLAG_Z !== zs[i]) begin
                failures++;
                $display("FAIL shift%0d ok=%b r0=%h z=%b exp=%h,%b",
                         i, ok, v, FLAG_Z, exp_v[i], zs[i]);
            end
        end
    endtask

    task automatic test_imm;
        logic [9:0] v;
        int st;
        logic ok, er;
        load_reg(2'd0, 10'h3F0);
        run(ri(2'b10, 2'd0, 6'd63), st, ok, er);
        peek(2'd0, v);
        checks++;
        if (!ok || st != 3 || v !== 10'h02F || er !== 1'b0) begin
            failures++;
            $display("FAIL addi ok=%b steps=%0d r0=%h err=%b exp=1,3,02f,0",
                     ok, st, v, er);
        end
        load_reg(2'd1, 10'h000);
        run(ri(2'b11, 2'd1, 6'd1), st, ok, er);
        peek(2'd1, v);
        checks++;
        if (!ok || v !== 10'h3FF || er !== 1'b0 || FLAG_N !== 1'b1) begin
            failures++;
            $display("FAIL subi ok=%b r1=%h err=%b n=%b exp=1,3ff,0,1",
                     ok, v, er, FLAG_N);
        end
    endtask

    task automatic test_illegal;
        logic [9:0] v;
        logic [9:0] exp_r [4];
        int st;
        logic ok, er;
        exp_r = '{10'h02F, 10'h3FF, 10'h001, 10'h3FA};
        run(10'b01_00_000000, st, ok, er);
        checks++;
        if (!ok || st != 1 || er !== 1'b1) begin
            failures++;
            $display("FAIL illegal_cls ok=%b steps=%0d err=%b exp=1,1,1", ok, st, er);
        end
        @(negedge CLKb);
        @(posedge CLKb);
        #1;
        checks++;
        if (ERR !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL illegal_pulse err=%b done=%b exp=0,0", ERR, DONE);
        end
        run(r2(4'hC, 2'd1, 2'd2), st, ok, er);
        checks++;
        if (!ok || er !== 1'b1 || FLAG_N !== 1'b1 || FLAG_Z !== 1'b0) begin
            failures++;
            $display("FAIL illegal_fn ok=%b err=%b n=%b z=%b exp=1,1,1,0",
                     ok, er, FLAG_N, FLAG_Z);
        end
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), v);
            checks++;
            if (v !== exp_r[i]) begin
                failures++;
                $display("FAIL illegal_reg%0d got=%h exp=%h", i, v, exp_r[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] v;
        @(posedge CLKb);
        INSTR = r2(4'h1, 2'd0, 2'd3);
        INSTR_VALID = 1'b1;
        @(negedge CLKb);
        @(posedge CLKb);
        INSTR = r2(4'h1, 2'd1, 2'd0);
        @(negedge CLKb);
        @(posedge CLKb);
        #1;
        checks++;
        if (DONE !== 1'b1 || TIME !== 2'd0 || INSTR_READY !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap done=%b time=%0d rdy=%b exp=1,0,1",
                     DONE, TIME, INSTR_READY);
        end
        @(negedge CLKb);
        @(posedge CLKb);
        INSTR_VALID = 1'b0;
        #1;
        checks++;
        if (TIME !== 2'd1 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept time=%0d done=%b exp=1,0", TIME, DONE);
        end
        @(negedge CLKb);
        @(posedge CLKb);
        #1;
        peek(2'd1, v);
        checks++;
        if (DONE !== 1'b1 || v !== 10'h3FA) begin
            failures++;
            $display("FAIL b2b_r1 done=%b r1=%h exp=1,3fa", DONE, v);
        end
    endtask

    task automatic test_clr_mid;
        logic [9:0] v;
        load_reg(2'd0, 10'd5);
        @(posedge CLKb);
        INSTR = r2(4'h2, 2'd0, 2'd1);
        INSTR_VALID = 1'b1;
        @(negedge CLKb);
        @(posedge CLKb);
        INSTR_VALID = 1'b0;
        CLR = 1'b1;
        #1;
        checks++;
        if (TIME !== 2'd1 || INSTR_READY !== 1'b0) begin
            failures++;
            $display("FAIL clr_pre time=%0d rdy=%b exp=1,0", TIME, INSTR_READY);
        end
        @(negedge CLKb);
        @(posedge CLKb);
        CLR = 1'b0;
        #1;
        checks++;
        if (INSTR_READY !== 1'b1 || TIME !== 2'd0 || FLAG_N !== 1'b0 ||
            FLAG_Z !== 1'b0 || DONE !== 1'b0 || BUS !== 10'h0) begin
            failures++;
            $display("FAIL clr_state rdy=%b time=%0d n=%b z=%b done=%b bus=%h",
                     INSTR_READY, TIME, FLAG_N, FLAG_Z, DONE, BUS);
        end
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), v);
            checks++;
            if (v !== 10'h0) begin
                failures++;
                $display("FAIL clr_reg%0d got=%h exp=000", i, v);
            end
        end
        @(negedge CLKb);
        @(posedge CLKb);
        #1;
        checks++;
        if (DONE !== 1'b0 || TIME !== 2'd0) begin
            failures++;
            $display("FAIL clr_no_resume done=%b time=%0d exp=0,0", DONE, TIME);
        end
    endtask

    initial begin
        test_reset();
        test_ld_stall();
        test_arith();
        test_unary();
        test_logic();
        test_shift();
        test_imm();
        test_illegal();
        test_back_to_back();
        test_clr_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
